// File: rtl/gcd_job_sequencer.sv
// Job sequencer for an external GCD engine: queues operand pairs in a 4-deep FIFO,
// runs one job at a time (or resolves zero-operand jobs locally) and holds the result.
module gcd_job_sequencer #(
  parameter int WAIT_CYC = 40,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic       go,
  output logic [3:0] xin,
  output logic [3:0] yin,
  input  logic [3:0] gcd,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_gcd,
  output logic [3:0] res_x,
  output logic [3:0] res_y,
  output logic       res_bypass,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [7:0] CNT_INIT = 8'(WAIT_CYC - 1);
  localparam logic [7:0] GO_LAST  = 8'(WAIT_CYC - 2);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [7:0] mem [0:3];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic [3:0] hx;
  logic [3:0] hy;
  logic       head_zero;

  assign in_ready  = (count < 3'(DEPTH));
  assign push      = in_valid & in_ready & ~clr;
  assign pop       = (state == IDLE) && (count != 3'd0);
  assign hx        = mem[rp][7:4];
  assign hy        = mem[rp][3:0];
  assign head_zero = (hx == 4'd0) || (hy == 4'd0);

  // go covers the first two RUN cycles: the counter still reads WAIT_CYC-1 or WAIT_CYC-2
  assign go        = (state == RUN) && (cnt >= GO_LAST);
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {in_x, in_y};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      xin        <= 4'd0;
      yin        <= 4'd0;
      res_gcd    <= 4'd0;
      res_x      <= 4'd0;
      res_y      <= 4'd0;
      res_bypass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            // a zero operand makes the answer the other operand; the engine is skipped
            if (head_zero) begin
              res_gcd    <= hx | hy;
              res_x      <= hx;
              res_y      <= hy;
              res_bypass <= 1'b1;
              state      <= HOLD;
            end else begin
              xin   <= hx;
              yin   <= hy;
              cnt   <= CNT_INIT;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (cnt == 8'd0) state <= CAP;
          else             cnt   <= cnt - 8'd1;
        end
        CAP: begin
          res_gcd    <= gcd;
          res_x      <= xin;
          res_y      <= yin;
          res_bypass <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed timing and result values.
module tb_gcd_job_sequencer;

  localparam int WAIT_CYC = 40;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_x = 4'd0;
  logic [3:0] in_y = 4'd0;
  logic       go;
  logic [3:0] xin, yin, gcd;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_gcd, res_x, res_y;
  logic       res_bypass;
  logic       busy;

  gcd_job_sequencer #(.WAIT_CYC(WAIT_CYC), .DEPTH(4)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .go(go), .xin(xin), .yin(yin), .gcd(gcd),
    .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd),
    .res_x(res_x), .res_y(res_y), .res_bypass(res_bypass), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gcd_f(input logic [3:0] a, input logic [3:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 4'(x);
  endfunction

  // engine stand-in: latches the answer while go is high
  logic [3:0] eng_res = 4'd0;
  always @(posedge clk) if (go === 1'b1) eng_res <= gcd_f(xin, yin);
  assign gcd = eng_res;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: queue of accepted pairs and the single outstanding job
  logic [7:0] q[$];
  bit         act_j = 1'b0;
  bit         jbyp = 1'b0;
  logic [3:0] jx = 4'd0, jy = 4'd0, lastx = 4'd0, lasty = 4'd0;
  int         pcyc = 0, rvcyc = 0;

  initial begin
    bit was, done, can_push;
    logic [7:0] p;
    forever begin
      @(posedge clk);
      if (clr === 1'b1) begin
        q.delete();
        act_j = 1'b0;
        lastx = 4'd0;
        lasty = 4'd0;
      end else begin
        was      = act_j;
        done     = act_j && (cyc >= rvcyc) && (res_ready === 1'b1);
        can_push = (in_valid === 1'b1) && (q.size() < 4);
        if (done) act_j = 1'b0;
        if (!was && q.size() > 0) begin
          p     = q.pop_front();
          jx    = p[7:4];
          jy    = p[3:0];
          jbyp  = (jx == 4'd0) || (jy == 4'd0);
          act_j = 1'b1;
          pcyc  = cyc;
          rvcyc = jbyp ? cyc + 1 : cyc + WAIT_CYC + 2;
          if (!jbyp) begin
            lastx = jx;
            lasty = jy;
          end
        end
        if (can_push) q.push_back({in_x, in_y});
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        ev = act_j && (cyc >= rvcyc);
        chk("in_ready", 32'(in_ready), 32'(q.size() < 4));
        chk("busy", 32'(busy), 32'(act_j));
        chk("res_valid", 32'(res_valid), 32'(ev));
        chk("go", 32'(go), 32'(act_j && !jbyp && (cyc == pcyc + 1 || cyc == pcyc + 2)));
        chk("xin", 32'(xin), 32'(lastx));
        chk("yin", 32'(yin), 32'(lasty));
        if (ev) begin
          chk("res_x", 32'(res_x), 32'(jx));
          chk("res_y", 32'(res_y), 32'(jy));
          chk("res_gcd", 32'(res_gcd), 32'(gcd_f(jx, jy)));
          chk("res_bypass", 32'(res_bypass), 32'(jbyp));
        end
      end
    end
  end

  // event log: go activity, rising res_valid cycles, completed handshakes
  int         go_first = -1;
  int         go_cnt = 0;
  logic [3:0] go_x = 4'd0, go_y = 4'd0;
  bit         prev_v = 1'b0;
  logic [12:0] res_log[$];
  int          rv_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (go === 1'b1) begin
          go_cnt++;
          if (go_first < 0) begin
            go_first = cyc;
            go_x = xin;
            go_y = yin;
          end
        end
        if (res_valid === 1'b1 && !prev_v) rv_log.push_back(cyc);
        if (res_valid === 1'b1 && res_ready === 1'b1)
          res_log.push_back({res_bypass, res_gcd, res_x, res_y});
        prev_v = (res_valid === 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 32'(res_valid), 32'd1);
  endtask

  task automatic chk_entry(input string nm, input int idx, input logic [12:0] exp);
    if (idx < res_log.size()) chk(nm, 32'(res_log[idx]), 32'(exp));
    else chk({nm, "_missing"}, 32'(res_log.size()), 32'(idx + 1));
  endtask

  initial begin
    int c0, acc, r0, v0, g0;
    logic [12:0] snap;
    int px[6] = '{9, 15, 7, 8, 14, 6};
    int py[6] = '{6, 10, 3, 12, 7, 4};
    int pg[6] = '{3, 5, 1, 4, 7, 2};

    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    mon_on = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_xy", 32'({xin, yin}), 32'd0);
    chk("rst_res", 32'({res_bypass, res_gcd, res_x, res_y}), 32'd0);

    // engine job (12,8)
    res_ready = 1'b1;
    go_first = -1;
    g0 = go_cnt; r0 = res_log.size(); v0 = rv_log.size();
    c0 = cyc;
    in_x = 4'd12; in_y = 4'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("eng", 60);
    chk("eng_valid_cycle", 32'(cyc - c0), 32'd43);
    tick(); tick();
    chk("eng_go_first", 32'(go_first - c0), 32'd2);
    chk("eng_go_count", 32'(go_cnt - g0), 32'd2);
    chk("eng_go_xy", 32'({go_x, go_y}), 32'({4'd12, 4'd8}));
    if (v0 < rv_log.size()) chk("eng_rv_cycle", 32'(rv_log[v0] - c0), 32'd43);
    else chk("eng_rv_missing", 32'(rv_log.size()), 32'(v0 + 1));
    chk_entry("eng_result", r0, {1'b0, 4'd4, 4'd12, 4'd8});

    // bypass jobs (0,9) then (0,0)
    g0 = go_cnt; r0 = res_log.size(); v0 = rv_log.size();
    c0 = cyc;
    in_x = 4'd0; in_y = 4'd9; in_valid = 1'b1;
    tick();
    in_x = 4'd0; in_y = 4'd0;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("byp_go_count", 32'(go_cnt - g0), 32'd0);
    chk_entry("byp_result0", r0, {1'b1, 4'd9, 4'd0, 4'd9});
    chk_entry("byp_result1", r0 + 1, {1'b1, 4'd0, 4'd0, 4'd0});
    chk("byp_count", 32'(res_log.size() - r0), 32'd2);
    if (v0 + 1 < rv_log.size()) begin
      chk("byp_rv0_cycle", 32'(rv_log[v0] - c0), 32'd2);
      chk("byp_rv1_cycle", 32'(rv_log[v0 + 1] - c0), 32'd4);
    end else chk("byp_rv_missing", 32'(rv_log.size()), 32'(v0 + 2));

    // full FIFO with backpressure, then drain in push order
    res_ready = 1'b0;
    r0 = res_log.size();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_x = 4'(px[i]); in_y = 4'(py[i]); in_valid = 1'b1;
      if (in_ready === 1'b1) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_valid("drain", 100);
      if (k == 0) begin
        snap = {res_bypass, res_gcd, res_x, res_y};
        for (int j = 0; j < 10; j++) begin
          tick();
          chk("bp_valid", 32'(res_valid), 32'd1);
          chk("bp_stable", 32'({res_bypass, res_gcd, res_x, res_y}), 32'(snap));
        end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("drain_handshake", 32'(res_valid), 32'd0);
    end
    chk("drain_count", 32'(res_log.size() - r0), 32'd5);
    for (int k = 0; k < 5; k++)
      chk_entry("drain_order", r0 + k, {1'b0, 4'(pg[k]), 4'(px[k]), 4'(py[k])});

    // clear in the middle of a RUN with two pairs queued
    res_ready = 1'b1;
    c0 = cyc;
    in_x = 4'd9; in_y = 4'd3; in_valid = 1'b1;
    tick();
    in_x = 4'd8; in_y = 4'd4;
    tick();
    in_x = 4'd10; in_y = 4'd5;
    tick();
    in_valid = 1'b0;
    while (cyc < c0 + 21) tick();
    clr = 1'b1;
    in_x = 4'd1; in_y = 4'd1; in_valid = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_go", 32'(go), 32'd0);
    chk("clr_res_valid", 32'(res_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_xy", 32'({xin, yin}), 32'd0);
    chk("clr_res", 32'({res_bypass, res_gcd, res_x, res_y}), 32'd0);
    v0 = rv_log.size();
    repeat (80) tick();
    chk("clr_no_result", 32'(rv_log.size() - v0), 32'd0);

    // push in the same cycle IDLE pops the queue head
    res_ready = 1'b0;
    r0 = res_log.size();
    in_x = 4'd0; in_y = 4'd5; in_valid = 1'b1;
    tick();
    in_x = 4'd3; in_y = 4'd0;
    tick();
    in_valid = 1'b0;
    wait_valid("sim", 10);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_x = 4'd6; in_y = 4'd9; in_valid = 1'b1;
    chk("sim_in_ready", 32'(in_ready), 32'd1);
    chk("sim_idle", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    res_ready = 1'b1;
    repeat (60) tick();
    chk("sim_count", 32'(res_log.size() - r0), 32'd3);
    chk_entry("sim_result0", r0, {1'b1, 4'd5, 4'd0, 4'd5});
    chk_entry("sim_result1", r0 + 1, {1'b1, 4'd3, 4'd3, 4'd0});
    chk_entry("sim_result2", r0 + 2, {1'b0, 4'd3, 4'd6, 4'd9});

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
